// File: rtl/dtof_pkg.sv
// Shared definitions for the dToF front end: timestamp width, the padding code and
// the serializer state encoding.
package dtof_pkg;

  localparam int NP           = 16;
  localparam logic [NP-1:0] NO_HIT = '1;

  localparam int DEF_PIXELS   = 4;
  localparam int DEF_DATA_NUM = 2;
  localparam int DEF_WINDOW   = 8;
  localparam int WORDS        = DEF_PIXELS * DEF_DATA_NUM;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } ser_state_t;

endpackage

// File: rtl/tdc_hit_serializer_if.sv
// Histogram-builder write port: one timestamp word per cycle, no backpressure.
interface tdc_hit_serializer_if #(
  parameter int NP     = dtof_pkg::NP,
  parameter int PIXELS = dtof_pkg::DEF_PIXELS,
  localparam int PW    = (PIXELS > 1) ? $clog2(PIXELS) : 1
);

  logic          wr_en;
  logic [NP-1:0] data;
  logic [PW-1:0] pix_idx;
  logic          acq_done;

  modport master (output wr_en, data, pix_idx, acq_done);
  modport slave  (input  wr_en, data, pix_idx, acq_done);

endinterface

// File: rtl/pixel_hit_slots.sv
// Arrival-ordered timestamp slots for one pixel, with a fill count and a read mux
// that looks at the post-write contents so a hit on the last capture edge is visible.
module pixel_hit_slots #(
  parameter int            NP       = 16,
  parameter int            DATA_NUM = 2,
  parameter logic [NP-1:0] NO_HIT   = '1,
  localparam int           SW       = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1,
  localparam int           CW       = $clog2(DATA_NUM + 1)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr,
  input  logic          cap_en,
  input  logic          hit_valid,
  input  logic [NP-1:0] hit_time,
  input  logic [SW-1:0] rd_slot,
  output logic [NP-1:0] rd_data,
  output logic          drop
);

  logic [NP-1:0] slot_q [DATA_NUM];
  logic [NP-1:0] slot_d [DATA_NUM];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, wr;

  assign full = (cnt_q == CW'(DATA_NUM));
  assign wr   = cap_en & hit_valid & ~full;
  assign drop = cap_en & hit_valid & full;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wr) begin
      slot_d[cnt_q[SW-1:0]] = hit_time;
      cnt_d                 = cnt_q + CW'(1);
    end
    rd_data = (CW'(rd_slot) < cnt_d) ? slot_d[rd_slot] : NO_HIT;
  end

  // NOTE: sequential state uses non-blocking assignment only; blocking stays in always_comb.
  always_ff @(posedge clk) begin
    if (res) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // NOTE: slot storage is deliberately not reset; a zero count masks stale contents.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

endmodule

// File: rtl/tdc_hit_serializer.sv
// Captures per-pixel TDC hits over a fixed window after laser_sync, then emits a
// fixed PIXELS*DATA_NUM word burst, pixel-major, padding empty slots with NO_HIT.
module tdc_hit_serializer #(
  parameter int            NP       = dtof_pkg::NP,
  parameter int            PIXELS   = dtof_pkg::DEF_PIXELS,
  parameter int            DATA_NUM = dtof_pkg::DEF_DATA_NUM,
  parameter int            WINDOW   = dtof_pkg::DEF_WINDOW,
  parameter logic [NP-1:0] NO_HIT   = '1,
  localparam int           PW       = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 laser_sync,
  input  logic [PIXELS-1:0]    hit_valid,
  input  logic [PIXELS*NP-1:0] hit_time,
  output logic                 wrEn,
  output logic [NP-1:0]        data,
  output logic [PW-1:0]        pix_idx,
  output logic                 acq_done,
  output logic                 overflow,
  output logic                 missed_sync,
  output logic                 busy
);

  import dtof_pkg::*;

  localparam int SW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  ser_state_t    state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic [PW-1:0] rd_pix_q, rd_pix_d;
  logic [SW-1:0] rd_slot_q, rd_slot_d;
  logic          wr_en_q, wr_en_d;
  logic [NP-1:0] data_q, data_d;
  logic [PW-1:0] pix_idx_q, pix_idx_d;
  logic          acq_done_q, acq_done_d;
  logic          overflow_q, overflow_d;
  logic          missed_q, missed_d;

  logic              clr, cap_en, emit;
  logic [NP-1:0]     pix_data [PIXELS];
  logic [PIXELS-1:0] drop;

  // Counts clear whenever a new acquisition may start: in IDLE and on the final drain cycle.
  assign cap_en = (state_q == CAPTURE);
  assign clr    = (state_q == IDLE) || ((state_q == DRAIN) && acq_done_q);

  for (genvar p = 0; p < PIXELS; p++) begin : g_pix
    pixel_hit_slots #(
      .NP       (NP),
      .DATA_NUM (DATA_NUM),
      .NO_HIT   (NO_HIT)
    ) u_slots (
      .clk       (clk),
      .res       (res),
      .clr       (clr),
      .cap_en    (cap_en),
      .hit_valid (hit_valid[p]),
      .hit_time  (hit_time[p*NP +: NP]),
      .rd_slot   (rd_slot_q),
      .rd_data   (pix_data[p]),
      .drop      (drop[p])
    );
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    rd_pix_d   = rd_pix_q;
    rd_slot_d  = rd_slot_q;
    wr_en_d    = 1'b0;
    data_d     = '0;
    pix_idx_d  = '0;
    acq_done_d = 1'b0;
    overflow_d = overflow_q | (|drop);
    missed_d   = missed_q;
    emit       = 1'b0;

    unique case (state_q)
      IDLE: begin
        win_d     = WW'(WINDOW - 1);
        rd_pix_d  = '0;
        rd_slot_d = '0;
        if (laser_sync) state_d = CAPTURE;
      end
      CAPTURE: begin
        missed_d = missed_q | laser_sync;
        if (win_q == '0) begin
          emit    = 1'b1;
          state_d = DRAIN;
        end else begin
          win_d = win_q - WW'(1);
        end
      end
      DRAIN: begin
        if (acq_done_q) begin
          win_d     = WW'(WINDOW - 1);
          rd_pix_d  = '0;
          rd_slot_d = '0;
          state_d   = laser_sync ? CAPTURE : IDLE;
        end else begin
          emit     = 1'b1;
          missed_d = missed_q | laser_sync;
        end
      end
      default: state_d = IDLE;
    endcase

    // Word 0 is launched on the last capture edge so the burst follows the window directly.
    if (emit) begin
      wr_en_d   = 1'b1;
      data_d    = pix_data[rd_pix_q];
      pix_idx_d = rd_pix_q;
      if (rd_slot_q == SW'(DATA_NUM - 1)) begin
        rd_slot_d = '0;
        if (rd_pix_q == PW'(PIXELS - 1)) acq_done_d = 1'b1;
        else                             rd_pix_d   = rd_pix_q + PW'(1);
      end else begin
        rd_slot_d = rd_slot_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      win_q      <= '0;
      rd_pix_q   <= '0;
      rd_slot_q  <= '0;
      wr_en_q    <= 1'b0;
      data_q     <= '0;
      pix_idx_q  <= '0;
      acq_done_q <= 1'b0;
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      rd_pix_q   <= rd_pix_d;
      rd_slot_q  <= rd_slot_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
      pix_idx_q  <= pix_idx_d;
      acq_done_q <= acq_done_d;
      overflow_q <= overflow_d;
      missed_q   <= missed_d;
    end
  end

  assign wrEn        = wr_en_q;
  assign data        = data_q;
  assign pix_idx     = pix_idx_q;
  assign acq_done    = acq_done_q;
  assign overflow    = overflow_q;
  assign missed_sync = missed_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tdc_hit_serializer.sv
// Scenario bench for tdc_hit_serializer: expected bursts come from a behavioural
// capture model and are compared word by word, including their arrival cycle.
module tb_tdc_hit_serializer;

  localparam int NP       = 16;
  localparam int PIXELS   = 4;
  localparam int DATA_NUM = 2;
  localparam int WINDOW   = 8;
  localparam int NSTIM    = 48;
  localparam int HMAX     = 2048;
  localparam logic [NP-1:0] PAD = 16'hFFFF;

  typedef struct {
    logic [NP-1:0] data;
    int            pix;
    logic          done;
    int            cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 res;
  logic                 laser_sync;
  logic [PIXELS-1:0]    hit_valid;
  logic [PIXELS*NP-1:0] hit_time;
  logic                 overflow, missed_sync, busy;

  tdc_hit_serializer_if #(.NP(NP), .PIXELS(PIXELS)) wr_if ();

  tdc_hit_serializer #(
    .NP(NP), .PIXELS(PIXELS), .DATA_NUM(DATA_NUM), .WINDOW(WINDOW)
  ) dut (
    .clk         (clk),
    .res         (res),
    .laser_sync  (laser_sync),
    .hit_valid   (hit_valid),
    .hit_time    (hit_time),
    .wrEn        (wr_if.wr_en),
    .data        (wr_if.data),
    .pix_idx     (wr_if.pix_idx),
    .acq_done    (wr_if.acq_done),
    .overflow    (overflow),
    .missed_sync (missed_sync),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Stimulus table, indexed by cycle offset from the scenario start.
  logic          sv [NSTIM];
  logic          rv [NSTIM];
  logic [PIXELS-1:0] vv [NSTIM];
  logic [NP-1:0] tv [NSTIM][PIXELS];
  int            acc_s[$];
  int            acc_n[$];
  int            base;
  exp_t          sb[$];

  logic          h_wr   [HMAX];
  logic          h_ovf  [HMAX];
  logic          h_miss [HMAX];
  logic          h_busy [HMAX];
  logic          h_done [HMAX];
  logic [1:0]    h_pix  [HMAX];
  logic [NP-1:0] h_dat  [HMAX];

  exp_t mon_e;
  always @(negedge clk) begin
    if (cyc < HMAX) begin
      h_wr[cyc]   = wr_if.wr_en;
      h_ovf[cyc]  = overflow;
      h_miss[cyc] = missed_sync;
      h_busy[cyc] = busy;
      h_done[cyc] = wr_if.acq_done;
      h_pix[cyc]  = wr_if.pix_idx;
      h_dat[cyc]  = wr_if.data;
    end
    if (wr_if.wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_word", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("word_data",  32'(wr_if.data),     32'(mon_e.data));
        check("word_pix",   32'(wr_if.pix_idx),  mon_e.pix);
        check("word_done",  32'(wr_if.acq_done), 32'(mon_e.done));
        check("word_cycle", cyc,                 mon_e.cyc);
      end
    end else if (wr_if.acq_done === 1'b1) begin
      check("done_without_wren", 32'd1, 32'd0);
    end
  end

  // Interval k of a scenario is the cycle whose closing edge samples stimulus index k.
  function automatic int h(input int k);
    return base + k - 1;
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < NSTIM; i++) begin
      sv[i] = 1'b0;
      rv[i] = 1'b0;
      vv[i] = '0;
      for (int p = 0; p < PIXELS; p++) tv[i][p] = '0;
    end
    acc_s.delete();
    acc_n.delete();
  endtask

  task automatic set_hit(input int i, input int p, input logic [NP-1:0] val);
    vv[i][p] = 1'b1;
    tv[i][p] = val;
  endtask

  task automatic accept(input int s, input int nwords);
    sv[s] = 1'b1;
    acc_s.push_back(s);
    acc_n.push_back(nwords);
  endtask

  task automatic expect_burst(input int s, input int nwords);
    logic [NP-1:0] sl [PIXELS][DATA_NUM];
    int            cnt [PIXELS];
    int            w;
    exp_t          e;
    for (int p = 0; p < PIXELS; p++) cnt[p] = 0;
    for (int i = s + 1; i <= s + WINDOW; i++)
      for (int p = 0; p < PIXELS; p++)
        if (vv[i][p] && cnt[p] < DATA_NUM) begin
          sl[p][cnt[p]] = tv[i][p];
          cnt[p]++;
        end
    w = 0;
    for (int p = 0; p < PIXELS; p++)
      for (int k = 0; k < DATA_NUM; k++) begin
        if (w < nwords) begin
          e.data = (k < cnt[p]) ? sl[p][k] : PAD;
          e.pix  = p;
          e.done = (p == PIXELS - 1) && (k == DATA_NUM - 1);
          e.cyc  = base + s + WINDOW + w;
          sb.push_back(e);
        end
        w++;
      end
  endtask

  task automatic drive_idle();
    res        = 1'b0;
    laser_sync = 1'b0;
    hit_valid  = '0;
    hit_time   = '0;
  endtask

  task automatic play(input int len);
    @(negedge clk);
    base = cyc + 1;
    foreach (acc_s[j]) expect_burst(acc_s[j], acc_n[j]);
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      res        = rv[i];
      laser_sync = sv[i];
      hit_valid  = vv[i];
      for (int p = 0; p < PIXELS; p++) hit_time[p*NP +: NP] = tv[i][p];
    end
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);
    check("burst_words_left", sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    res = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wren",     32'(wr_if.wr_en),    32'd0);
    check("rst_data",     32'(wr_if.data),     32'd0);
    check("rst_pix",      32'(wr_if.pix_idx),  32'd0);
    check("rst_done",     32'(wr_if.acq_done), 32'd0);
    check("rst_overflow", 32'(overflow),       32'd0);
    check("rst_missed",   32'(missed_sync),    32'd0);
    check("rst_busy",     32'(busy),           32'd0);
    res = 1'b0;

    // Single hit on pixel 2.
    clear_stim();
    accept(0, dtof_pkg::WORDS);
    set_hit(3, 2, 16'h1234);
    play(20);
    check("s1_busy_t0",  32'(h_busy[h(0)]),  32'd0);
    check("s1_busy_t1",  32'(h_busy[h(1)]),  32'd1);
    check("s1_wren_t8",  32'(h_wr[h(8)]),    32'd0);
    check("s1_wren_t17", 32'(h_wr[h(17)]),   32'd0);
    check("s1_busy_t17", 32'(h_busy[h(17)]), 32'd0);
    check("s1_ovf",      32'(h_ovf[h(17)]),  32'd0);

    // Full slots on pixel 0: third hit dropped.
    do_reset();
    clear_stim();
    accept(0, dtof_pkg::WORDS);
    set_hit(1, 0, 16'h0010);
    set_hit(2, 0, 16'h0020);
    set_hit(3, 0, 16'h0030);
    play(22);
    check("s2_ovf_t3",  32'(h_ovf[h(3)]),  32'd0);
    check("s2_ovf_t4",  32'(h_ovf[h(4)]),  32'd1);
    check("s2_ovf_t20", 32'(h_ovf[h(20)]), 32'd1);

    // Parallel hits on the last capture cycle; the following cycle's hits are ignored.
    do_reset();
    clear_stim();
    accept(0, dtof_pkg::WORDS);
    for (int p = 0; p < PIXELS; p++) begin
      set_hit(8, p, 16'h0A00 + 16'(p));
      set_hit(9, p, 16'h0B00 + 16'(p));
    end
    play(20);
    check("s3_ovf", 32'(h_ovf[h(17)]), 32'd0);

    // Back-to-back syncs at the minimum period; a hit during drain is ignored.
    do_reset();
    clear_stim();
    accept(0, dtof_pkg::WORDS);
    accept(16, dtof_pkg::WORDS);
    set_hit(5, 1, 16'h0555);
    set_hit(12, 0, 16'h0DEA);
    set_hit(20, 3, 16'h0777);
    set_hit(22, 3, 16'h0778);
    play(36);
    check("s4_missed", 32'(h_miss[h(33)]), 32'd0);
    check("s4_busy_t17", 32'(h_busy[h(17)]), 32'd1);

    // Sync mid-drain is dropped and flagged.
    do_reset();
    clear_stim();
    accept(0, dtof_pkg::WORDS);
    sv[12] = 1'b1;
    set_hit(6, 3, 16'h0C0C);
    play(24);
    check("s4b_missed_t12", 32'(h_miss[h(12)]), 32'd0);
    check("s4b_missed_t13", 32'(h_miss[h(13)]), 32'd1);
    check("s4b_missed_t22", 32'(h_miss[h(22)]), 32'd1);

    // Reset mid-drain (with a simultaneous sync), then a fresh acquisition.
    do_reset();
    clear_stim();
    accept(0, 3);
    sv[5]  = 1'b1;
    set_hit(1, 2, 16'h0201);
    set_hit(2, 2, 16'h0202);
    set_hit(3, 2, 16'h0203);
    set_hit(2, 0, 16'h0111);
    set_hit(4, 3, 16'h0333);
    rv[11] = 1'b1;
    sv[11] = 1'b1;
    accept(14, dtof_pkg::WORDS);
    set_hit(15, 1, 16'h0999);
    set_hit(16, 2, 16'h0AAA);
    play(34);
    check("s5_ovf_t11",   32'(h_ovf[h(11)]),  32'd1);
    check("s5_miss_t11",  32'(h_miss[h(11)]), 32'd1);
    check("s5_wren_t12",  32'(h_wr[h(12)]),   32'd0);
    check("s5_busy_t12",  32'(h_busy[h(12)]), 32'd0);
    check("s5_ovf_t12",   32'(h_ovf[h(12)]),  32'd0);
    check("s5_miss_t12",  32'(h_miss[h(12)]), 32'd0);
    check("s5_data_t12",  32'(h_dat[h(12)]),  32'd0);
    check("s5_pix_t12",   32'(h_pix[h(12)]),  32'd0);
    check("s5_done_t12",  32'(h_done[h(12)]), 32'd0);
    check("s5_busy_t14",  32'(h_busy[h(14)]), 32'd0);
    check("s5_busy_t15",  32'(h_busy[h(15)]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
